// File: rtl/level_meter.sv
// level_meter: 4-LED bar graph with envelope, peak hold and clip flag; in clk_i/srst_i/sample_tick_i/sample_i, out leds_o (bit 0 = lowest LED)
module level_meter #(
  parameter int DW          = 16,
  parameter int THR_1       = 1024,
  parameter int THR_2       = 4096,
  parameter int THR_3       = 12288,
  parameter int THR_4       = 24576,
  parameter int DECAY_SHIFT = 10,
  parameter int HOLD_TICKS  = 24000,
  parameter int CLIP_THR    = 32000,
  parameter int CLIP_TICKS  = 24000
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 sample_tick_i,
  input  logic signed [DW-1:0] sample_i,
  output logic [3:0]           leds_o
);
  localparam int MW = DW - 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam int CW = $clog2(CLIP_TICKS) + 1;
  localparam logic [MW-1:0] T1 = MW'(THR_1);
  localparam logic [MW-1:0] T2 = MW'(THR_2);
  localparam logic [MW-1:0] T3 = MW'(THR_3);
  localparam logic [MW-1:0] T4 = MW'(THR_4);
  localparam logic [MW-1:0] CT = MW'(CLIP_THR);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_TICKS);
  localparam logic [CW-1:0] CLIP = CW'(CLIP_TICKS);
  logic [DW-1:0] neg;
  logic [MW-1:0] mag, env, env_nxt, dec;
  logic [3:0] bar_nxt;
  logic [2:0] lvl_nxt, peak;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] clip_cnt;
  function automatic logic [3:0] therm(input logic [MW-1:0] e);
    return {e >= T4, e >= T3, e >= T2, e >= T1};
  endfunction
  assign neg = -sample_i;
  // only the most negative input still has its top bit set after negation
  assign mag = !sample_i[DW-1] ? sample_i[MW-1:0] : neg[DW-1] ? '1 : neg[MW-1:0];
  assign dec = env >> DECAY_SHIFT;
  assign env_nxt = mag > env ? mag : env != '0 ? env - (dec == '0 ? MW'(1) : dec) : '0;
  assign bar_nxt = therm(env_nxt);
  assign lvl_nxt = 3'(bar_nxt[0]) + 3'(bar_nxt[1]) + 3'(bar_nxt[2]) + 3'(bar_nxt[3]);
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      env      <= '0;
      peak     <= '0;
      hold_cnt <= '0;
      clip_cnt <= '0;
      leds_o   <= '0;
    end else begin
      if (sample_tick_i) begin
        env <= env_nxt;
        if (lvl_nxt >= peak) begin
          peak     <= lvl_nxt;
          hold_cnt <= HOLD;
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
        end else begin
          peak     <= peak - 1'b1;
          hold_cnt <= HOLD;
        end
        clip_cnt <= mag >= CT ? CLIP : clip_cnt != '0 ? clip_cnt - 1'b1 : '0;
      end
      // second pipeline stage: peak dot is bit (peak-1), nothing when peak is 0
      leds_o <= clip_cnt != '0 ? 4'hf : therm(env) | 4'((5'd1 << peak) >> 1);
    end
  end
endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: scoreboard bench for level_meter with shortened timers
module tb_level_meter;
  localparam int DS = 4;
  localparam int HOLD = 20;
  localparam int CLIPT = 30;
  logic clk_i = 0;
  logic srst_i = 1;
  logic sample_tick_i = 0;
  logic signed [15:0] sample_i = 0;
  logic [3:0] leds_o;
  int pass = 0, total = 0, fails = 0;
  int m_env = 0, m_peak = 0, m_hold = 0, m_clip = 0;
  logic [3:0] sb[$];
  string tag = "init";
  level_meter #(.DECAY_SHIFT(DS), .HOLD_TICKS(HOLD), .CLIP_TICKS(CLIPT)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .sample_tick_i(sample_tick_i),
    .sample_i(sample_i), .leds_o(leds_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic int lvl_of(input int e);
    return int'(e >= 1024) + int'(e >= 4096) + int'(e >= 12288) + int'(e >= 24576);
  endfunction
  function automatic logic [3:0] m_leds();
    logic [3:0] bar, dot;
    bar = 4'((1 << lvl_of(m_env)) - 1);
    dot = m_peak == 0 ? 4'b0 : 4'(1 << (m_peak - 1));
    return m_clip != 0 ? 4'b1111 : bar | dot;
  endfunction
  task automatic chk(input string t, input logic [3:0] o, input logic [3:0] e);
    total++;
    assert (o === e) pass++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", t, o, e);
    end
  endtask
  task automatic step(input logic t, input logic signed [15:0] s, input logic r);
    int sv, mag, d, l;
    logic [3:0] e;
    sv = s;
    mag = sv == -32768 ? 32767 : (sv < 0 ? -sv : sv);
    sb.push_back(r ? 4'b0 : m_leds());
    if (r) begin
      m_env = 0; m_peak = 0; m_hold = 0; m_clip = 0;
    end else if (t) begin
      if (mag > m_env) m_env = mag;
      else if (m_env != 0) begin
        d = m_env >> DS;
        m_env -= d < 1 ? 1 : d;
      end
      l = lvl_of(m_env);
      if (l >= m_peak) begin
        m_peak = l; m_hold = HOLD;
      end else if (m_hold != 0) m_hold--;
      else begin
        m_peak--; m_hold = HOLD;
      end
      if (mag >= 32000) m_clip = CLIPT;
      else if (m_clip != 0) m_clip--;
    end
    srst_i = r;
    sample_tick_i = t;
    sample_i = s;
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk(tag, leds_o, e);
  endtask
  initial begin
    logic [3:0] held;
    logic signed [15:0] seq [8];
    seq = '{16'sd0, 16'sd2000, -16'sd8000, 16'sd15000, -16'sd30000, 16'sd100, 16'sd0, 16'sd32001};
    tag = "reset";
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_state", leds_o, 4'b0000);
    tag = "attack";
    step(1, -16'sd5000, 0);
    step(0, 0, 0);
    chk("attack_bar", leds_o, 4'b0011);
    tag = "decay";
    step(1, 16'sd20000, 0);
    step(0, 0, 0);
    chk("decay_start", leds_o, 4'b0111);
    for (int i = 0; i < 400; i++) step(1, 0, 0);
    chk("decay_floor", leds_o, 4'b0000);
    tag = "clip";
    step(1, 16'sd32000, 0);
    step(0, 0, 0);
    chk("clip_on", leds_o, 4'b1111);
    for (int i = 0; i < 14; i++) step(1, 0, 0);
    step(1, 16'sd32767, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("clip_retrig", leds_o, 4'b1111);
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    tag = "sat";
    step(1, -16'sd32768, 0);
    step(0, 0, 0);
    chk("sat_clip", leds_o, 4'b1111);
    for (int i = 0; i < 35; i++) step(1, 16'sd30000, 0);
    step(0, 16'sd30000, 0);
    chk("sat_bar", leds_o, 4'b1111);
    tag = "gap";
    held = leds_o;
    for (int i = 0; i < 1000; i++) step(0, 16'sd30000, 0);
    chk("gap_stable", leds_o, held);
    tag = "b2b";
    for (int i = 0; i < 8; i++) step(1, seq[i], 0);
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    tag = "random";
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 0);
    tag = "midreset";
    step(1, 16'sd32767, 0);
    step(1, 16'sd31000, 0);
    step(1, -16'sd32768, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset_release", leds_o, 4'b0000);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("reset_zero_tick", leds_o, 4'b0000);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
